// File: rtl/streambuf_pp.sv
// Ping-pong stream buffer: a writer fills one bank with a frame while a reader
// drains the other. Both sides use valid/ready handshakes, and frame length is replayed on out_last.
module streambuf_pp #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [1:0]            frames_stored
);

    localparam int                    FRAME_MAX = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(FRAME_MAX - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [2][FRAME_MAX];

    logic [1:0]                 full_q, full_d;
    logic [1:0][ADDR_WIDTH-1:0] len_q, len_d;
    logic                       wbank_q, wbank_d;
    logic                       rbank_q, rbank_d;
    logic [ADDR_WIDTH-1:0]      waddr_q, waddr_d;
    logic [ADDR_WIDTH-1:0]      raddr_q, raddr_d;

    logic wr_fire;
    logic rd_fire;
    logic wr_close;

    // Handshake flags come only from registered state, so there is no
    // combinational path across the two sides of the buffer.
    assign in_ready      = ~full_q[wbank_q];
    assign out_valid     = full_q[rbank_q];
    assign out_data      = mem_q[rbank_q][raddr_q];
    assign out_last      = out_valid && (raddr_q == len_q[rbank_q]);
    assign frames_stored = {1'b0, full_q[0]} + {1'b0, full_q[1]};

    assign wr_fire  = in_valid && in_ready;
    assign rd_fire  = out_valid && out_ready;
    assign wr_close = in_last || (waddr_q == ADDR_LAST);

    // NOTE: every signal assigned here gets its default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        full_d  = full_q;
        len_d   = len_q;
        wbank_d = wbank_q;
        rbank_d = rbank_q;
        waddr_d = waddr_q;
        raddr_d = raddr_q;

        // A firing write targets an empty bank and a firing read a full one,
        // so the two updates below never touch the same bank.
        if (wr_fire) begin
            if (wr_close) begin
                len_d[wbank_q]  = waddr_q;
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
                waddr_d         = '0;
            end else begin
                waddr_d = waddr_q + ADDR_ONE;
            end
        end

        if (rd_fire) begin
            if (out_last) begin
                full_d[rbank_q] = 1'b0;
                rbank_d         = ~rbank_q;
                raddr_d         = '0;
            end else begin
                raddr_d = raddr_q + ADDR_ONE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            full_q  <= '0;
            len_q   <= '0;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            waddr_q <= '0;
            raddr_q <= '0;
        end else begin
            full_q  <= full_d;
            len_q   <= len_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            waddr_q <= waddr_d;
            raddr_q <= raddr_d;
        end
    end

    // NOTE: the storage array has no reset. A word is readable only after full_q
    // marks its bank valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (rst && wr_fire) begin
            mem_q[wbank_q][waddr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_streambuf_pp.sv
// Self-checking bench for streambuf_pp. It uses a frame-queue reference model with
// directed scenarios and randomized back-pressure.
module tb_streambuf_pp;

    localparam int DW        = 16;
    localparam int AW        = 2;
    localparam int FRAME_MAX = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [1:0]    frames_stored;

    int errors = 0;
    int checks = 0;

    // Reference model: complete frames as a flat word queue with end-of-frame
    // flags, plus the frame currently being written.
    logic [DW-1:0] st_w [$];
    logic          st_l [$];
    logic [DW-1:0] part [$];
    int            m_frames = 0;

    streambuf_pp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .frames_stored (frames_stored)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        check("in_ready", 32'(in_ready), 32'(m_frames < 2));
        check("out_valid", 32'(out_valid), 32'(m_frames > 0));
        check("frames_stored", 32'(frames_stored), 32'(m_frames));
        check("frames_le2", 32'(frames_stored <= 2'd2), 32'd1);
        if (m_frames > 0) begin
            check("out_data", 32'(out_data), 32'(st_w[0]));
            check("out_last", 32'(out_last), 32'(st_l[0]));
        end else begin
            check("out_last_idle", 32'(out_last), 32'd0);
        end
    endtask

    // One clock cycle: drive at the falling edge, compare, then apply the model's edge update.
    task automatic cycle(input logic iv, input logic [DW-1:0] d, input logic il, input logic ordy);
        logic wf;
        logic rf;
        logic lf;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        in_last   = il;
        out_ready = ordy;
        #1;
        compare_outputs();
        wf = iv && (m_frames < 2);
        rf = ordy && (m_frames > 0);
        @(posedge clk);
        if (rf) begin
            lf = st_l.pop_front();
            void'(st_w.pop_front());
            if (lf) m_frames--;
        end
        if (wf) begin
            part.push_back(d);
            if (il || part.size() == FRAME_MAX) begin
                for (int i = 0; i < part.size(); i++) begin
                    st_w.push_back(part[i]);
                    st_l.push_back(i == part.size() - 1);
                end
                part.delete();
                m_frames++;
            end
        end
        #1;
    endtask

    // Reset is held while both handshakes are active, so it must win over them.
    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hBEEF;
        in_last   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        st_w.delete();
        st_l.delete();
        part.delete();
        m_frames = 0;
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_frames", 32'(frames_stored), 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        do_reset();

        // A full-length frame closes automatically without in_last.
        for (int i = 0; i < 4; i++) cycle(1'b1, DW'(16'hA000 + i), 1'b0, 1'b0);
        check("a_frames_1", 32'(frames_stored), 32'd1);
        check("a_out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        check("a_drained", 32'(frames_stored), 32'd0);

        // A short frame is closed by in_last, and the next frame starts in the other bank.
        cycle(1'b1, 16'h0011, 1'b0, 1'b0);
        cycle(1'b1, 16'h0022, 1'b1, 1'b0);
        check("short_frames", 32'(frames_stored), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b1, DW'(16'hB000 + i), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1);

        // With both banks full, the ninth write is refused until a frame drains.
        for (int i = 0; i < 8; i++) cycle(1'b1, DW'(16'hC000 + i), 1'b0, 1'b0);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_frames", 32'(frames_stored), 32'd2);
        cycle(1'b1, 16'hDEAD, 1'b1, 1'b0);
        check("ninth_ignored", 32'(frames_stored), 32'd2);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        check("before_last_rdy", 32'(in_ready), 32'd0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        check("freed_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1);

        // Continuous streaming runs 5 frames back to back. The model requires out_valid on every cycle after the first close.
        for (int i = 0; i < 20; i++) cycle(1'b1, DW'(16'h5000 + i), (i % 4) == 3, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        check("stream_empty", 32'(frames_stored), 32'd0);

        // Reset arrives mid-frame with one complete frame stored.
        for (int i = 0; i < 6; i++) cycle(1'b1, DW'(16'hE000 + i), 1'b0, 1'b0);
        check("pre_rst_frames", 32'(frames_stored), 32'd1);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, 16'h7001, 1'b0, 1'b1);
        cycle(1'b1, 16'h7002, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1);

        // Random back-pressure with random early termination.
        for (int n = 0; n < 2000; n++) begin
            cycle(($urandom % 4) != 0, DW'($urandom), ($urandom % 4) == 0, ($urandom % 3) != 0);
        end
        for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
